// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the iterative shifter family.
// Step and shift-amount widths are derived from the operand width.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_e;

  function automatic int shamt_w(input int data_w);
    return $clog2(data_w);
  endfunction

  function automatic int num_steps(input int data_w, input int spc);
    return (shamt_w(data_w) + spc - 1) / spc;
  endfunction

  function automatic int step_w(input int data_w, input int spc);
    return (num_steps(data_w, spc) > 1) ? $clog2(num_steps(data_w, spc)) : 1;
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One combinational left-shift stage that resolves SPC shift-amount bits.
// The bit group is selected by the step index, so weights are 2**(step*SPC+k).
module sll_stage
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SPC    = 1,
  parameter int STEP_W = 3
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SPC-1:0]    bits,
  input  logic [STEP_W-1:0] step,
  output logic [DATA_W-1:0] shifted
);

  localparam int SHAMT_W = shamt_w(DATA_W);

  always_comb begin
    shifted = data;
    for (int k = 0; k < SPC; k++) begin
      // Positions past the top shift-amount bit only exist in a partial last step.
      if (bits[k] && ((int'(step) * SPC + k) < SHAMT_W)) begin
        shifted = shifted << (1 << (int'(step) * SPC + k));
      end
    end
  end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: one small stage reused over NUM_STEPS cycles.
// Handshake: input accepted on valid_i && ready_o && !flush_i; result consumed on valid_o && ready_i.
module sll_iter
  import shift_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_W-1:0]         operand_a_i,
  input  logic [$clog2(DATA_W)-1:0] operand_b_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         sll_data_o,
  output shift_state_e              state_o
);

  localparam int SHAMT_W   = shamt_w(DATA_W);
  localparam int NUM_STEPS = num_steps(DATA_W, STAGES_PER_CYCLE);
  localparam int STEP_W    = step_w(DATA_W, STAGES_PER_CYCLE);
  localparam int PAD_W     = NUM_STEPS * STAGES_PER_CYCLE;

  shift_state_e                state_q;
  logic [DATA_W-1:0]           result_q;
  logic [SHAMT_W-1:0]          shamt_q;
  logic [STEP_W-1:0]           step_q;
  logic                        ready_q;
  logic                        valid_q;
  logic [PAD_W-1:0]            shamt_pad;
  logic [STAGES_PER_CYCLE-1:0] stage_bits;
  logic [DATA_W-1:0]           stage_out;

  // Zero padding makes the last, possibly partial, bit group safe to slice.
  always_comb begin
    shamt_pad  = PAD_W'(shamt_q);
    stage_bits = STAGES_PER_CYCLE'(shamt_pad >> (int'(step_q) * STAGES_PER_CYCLE));
  end

  sll_stage #(
    .DATA_W (DATA_W),
    .SPC    (STAGES_PER_CYCLE),
    .STEP_W (STEP_W)
  ) u_stage (
    .data    (result_q),
    .bits    (stage_bits),
    .step    (step_q),
    .shifted (stage_out)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      result_q <= '0;
      shamt_q  <= '0;
      step_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            result_q <= operand_a_i;
            shamt_q  <= operand_b_i;
            step_q   <= '0;
            ready_q  <= 1'b0;
            if (operand_b_i == '0) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          result_q <= stage_out;
          step_q   <= step_q + 1'b1;
          if (step_q == STEP_W'(NUM_STEPS - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign sll_data_o = result_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sll_iter.sv
// Bench for sll_iter: a default build (one bit per cycle) and a two-bits-per-cycle build.
// Drivers push expected results and first-valid cycles; a negedge monitor pops and compares.
module tb_sll_iter;
  import shift_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         flush_i  [2];
  logic         valid_i  [2];
  logic         ready_o  [2];
  logic [31:0]  op_a     [2];
  logic [4:0]   op_b     [2];
  logic         valid_o  [2];
  logic         ready_i  [2];
  logic [31:0]  data_o   [2];
  shift_state_e state_o  [2];

  logic [31:0]  exp_q    [2][$];
  int           cyc_q    [2][$];
  logic         prev_v   [2];
  logic         hs_prev  [2];
  int           ncyc;
  int           n_checks;
  int           n_fail;

  sll_iter #(.DATA_W(32), .STAGES_PER_CYCLE(1)) u_dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush_i[0]),
    .valid_i     (valid_i[0]),
    .ready_o     (ready_o[0]),
    .operand_a_i (op_a[0]),
    .operand_b_i (op_b[0]),
    .valid_o     (valid_o[0]),
    .ready_i     (ready_i[0]),
    .sll_data_o  (data_o[0]),
    .state_o     (state_o[0])
  );

  sll_iter #(.DATA_W(32), .STAGES_PER_CYCLE(2)) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush_i[1]),
    .valid_i     (valid_i[1]),
    .ready_o     (ready_o[1]),
    .operand_a_i (op_a[1]),
    .operand_b_i (op_b[1]),
    .valid_o     (valid_o[1]),
    .ready_i     (ready_i[1]),
    .sll_data_o  (data_o[1]),
    .state_o     (state_o[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // monitor / scoreboard
  task automatic monitor_one(input int s);
    if (hs_prev[s]) begin
      chk($sformatf("ready_back_%0d", s), {31'b0, ready_o[s]}, 32'd1);
      hs_prev[s] = 1'b0;
    end
    if (valid_o[s]) begin
      if (exp_q[s].size() == 0) begin
        chk($sformatf("spurious_valid_%0d", s), {31'b0, valid_o[s]}, 32'd0);
      end else begin
        if (!prev_v[s]) chk($sformatf("latency_%0d", s), ncyc, cyc_q[s][0]);
        chk($sformatf("data_%0d", s), data_o[s], exp_q[s][0]);
        chk($sformatf("ready_in_done_%0d", s), {31'b0, ready_o[s]}, 32'd0);
        if (ready_i[s]) begin
          void'(exp_q[s].pop_front());
          void'(cyc_q[s].pop_front());
          hs_prev[s] = 1'b1;
        end
      end
    end
    prev_v[s] = valid_o[s];
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush_i[0]) monitor_one(0);
    if (rst_n && !flush_i[1]) monitor_one(1);
  end

  // driver tasks (entered and left at a negedge)
  task automatic issue(input int s, input logic [31:0] a, input logic [4:0] b,
                       input logic [31:0] exp);
    int t;
    int steps;
    t = 0;
    while (!ready_o[s] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("ready_wait_%0d", s), {31'b0, ready_o[s]}, 32'd1);
    steps = (s == 0) ? 5 : 3;
    op_a[s]    = a;
    op_b[s]    = b;
    valid_i[s] = 1'b1;
    exp_q[s].push_back(exp);
    cyc_q[s].push_back(ncyc + 1 + ((b == 5'd0) ? 0 : steps));
    @(negedge clk);
    valid_i[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int t;
    t = 0;
    while ((exp_q[s].size() != 0 || !ready_o[s]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_%0d", s), exp_q[s].size(), 32'd0);
  endtask

  task automatic drop_pending();
    for (int s = 0; s < 2; s++) begin
      exp_q[s].delete();
      cyc_q[s].delete();
      prev_v[s]  = 1'b0;
      hs_prev[s] = 1'b0;
    end
  endtask

  // stimulus
  initial begin
    logic [31:0] ra;
    logic [4:0]  rb;
    int          t;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int s = 0; s < 2; s++) begin
      flush_i[s] = 1'b0;
      valid_i[s] = 1'b0;
      ready_i[s] = 1'b1;
      op_a[s]    = '0;
      op_b[s]    = '0;
      prev_v[s]  = 1'b0;
      hs_prev[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_ready_%0d", s), {31'b0, ready_o[s]}, 32'd1);
      chk($sformatf("reset_valid_%0d", s), {31'b0, valid_o[s]}, 32'd0);
      chk($sformatf("reset_data_%0d", s), data_o[s], 32'h0);
    end

    // directed: max shift, zero shift, mid shifts
    issue(0, 32'h0000_0001, 5'd31, 32'h8000_0000);
    wait_idle(0);
    issue(0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    wait_idle(0);
    issue(0, 32'hA5A5_0F0F, 5'd1, 32'h4B4A_1E1E);
    issue(0, 32'hA5A5_0F0F, 5'd16, 32'h0F0F_0000);
    wait_idle(0);

    // consumer stall: result must hold while ready_i is low
    ready_i[0] = 1'b0;
    issue(0, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0);
    t = 0;
    while (!valid_o[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", {31'b0, valid_o[0]}, 32'd1);
    repeat (3) @(negedge clk);
    ready_i[0] = 1'b1;
    wait_idle(0);

    // flush in the second SHIFT cycle
    issue(0, 32'h1234_5678, 5'd8, 32'h3456_7800);
    @(negedge clk);
    flush_i[0] = 1'b1;
    exp_q[0].delete();
    cyc_q[0].delete();
    @(negedge clk);
    flush_i[0] = 1'b0;
    chk("flush_state", 32'(state_o[0]), 32'(IDLE));
    chk("flush_ready", {31'b0, ready_o[0]}, 32'd1);
    chk("flush_valid", {31'b0, valid_o[0]}, 32'd0);
    repeat (8) @(negedge clk);
    issue(0, 32'h1234_5678, 5'd8, 32'h3456_7800);
    wait_idle(0);

    // reset mid-SHIFT drops the operation
    issue(0, 32'h0000_0005, 5'd20, 32'h0050_0000);
    @(negedge clk);
    rst_n = 1'b0;
    drop_pending();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_ready", {31'b0, ready_o[0]}, 32'd1);
    chk("midreset_valid", {31'b0, valid_o[0]}, 32'd0);
    chk("midreset_data", data_o[0], 32'h0);
    repeat (8) @(negedge clk);

    // two-bits-per-cycle build
    issue(1, 32'h0000_00FF, 5'd13, 32'h001F_E000);
    wait_idle(1);
    issue(1, 32'h0000_0003, 5'd31, 32'h8000_0000);
    issue(1, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D);
    issue(1, 32'h8765_4321, 5'd17, 32'h8642_0000);
    wait_idle(1);

    // random operands against a << b
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      issue(1, ra, rb, ra << rb);
    end
    wait_idle(1);
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      issue(0, ra, rb, ra << rb);
    end
    wait_idle(0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
